// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and serial line levels,
// reused by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLOCKS_PER_BIT-1 and flags the last cycle of each bit
// period. Shared by the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int unsigned CLOCKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLOCKS_PER_BIT - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LastCnt);
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word from the upstream FIFO and sends it LSB first
// as start/data/[parity]/stop. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CLOCKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BitCntW = $clog2(WIDTH + 1);
  localparam logic [BitCntW-1:0] LastDataBit = BitCntW'(WIDTH - 1);
  localparam logic [BitCntW-1:0] LastStopBit = BitCntW'(STOP_BITS - 1);

  uart_tx_state_t     state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               baud_clear;
  logic               tick;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Hold the baud counter at zero until the frame starts so START is a full bit.
  assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

  uart_baud_gen #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud_gen (
    .clock(clock),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (tx_enable && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        state_d = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastDataBit) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LastStopBit) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_pop   = (state_q == IDLE) && tx_enable && !fifo_empty && !reset;
    busy       = (state_q != IDLE);
    frame_done = (state_q == STOP) && tick && (bit_cnt_q == LastStopBit);
    tx         = UART_IDLE_LEVEL;
    unique case (state_q)
      START:   tx = UART_START_LEVEL;
      DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = parity_q;
`endif
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with a one-cycle-latency FIFO model.
// Honours UART_TX_PARITY_EN when building expected frames.
module tb_uart_tx;

  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 4;
  localparam int unsigned SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NB = 1 + W + P + SB;

  logic         clock = 1'b0;
  logic         reset;
  logic         tx_enable;
  logic         fifo_empty = 1'b1;
  logic         fifo_pop;
  logic [W-1:0] fifo_data = '0;
  logic         tx;
  logic         busy;
  logic         frame_done;

  logic [W-1:0] fq[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int double_pop = 0;
  logic prev_pop = 1'b0;

  uart_tx #(
    .WIDTH         (W),
    .CLOCKS_PER_BIT(CPB),
    .STOP_BITS     (SB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tx_enable (tx_enable),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // FIFO model: head word appears the cycle after the pop; empty pop yields 0.
  always @(posedge clock) begin
    if (fifo_pop) begin
      if (fq.size() > 0) fifo_data <= fq.pop_front();
      else fifo_data <= '0;
    end
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clock) begin
    if (fifo_pop) pop_cnt++;
    if (fifo_pop && prev_pop) double_pop++;
    prev_pop = fifo_pop;
  end

  task automatic capture_frame(input logic [W-1:0] data, input int drop_at, output int gap);
    int   waited;
    int   b;
    int   done_cyc;
    logic exp_bits[16];
    logic obs_bits[16];
    bit   bad[16];
    bit   done_bad;
    bit   busy_bad;
    waited   = 0;
    gap      = -1;
    done_bad = 0;
    busy_bad = 0;
    done_cyc = -1;
    do begin
      @(negedge clock);
      waited++;
    end while (tx !== 1'b0 && waited < 300);
    if (tx !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL start_timeout: tx=%b after %0d cycles, required 0", tx, waited);
      return;
    end
    gap = waited - 1;
    for (int i = 0; i < 16; i++) begin
      exp_bits[i] = 1'b1;
      obs_bits[i] = 1'bx;
      bad[i]      = 0;
    end
    exp_bits[0] = 1'b0;
    for (int i = 0; i < int'(W); i++) exp_bits[1+i] = data[i];
    if (P == 1) exp_bits[1+W] = ^data;
    for (int c = 1; c <= int'(NB * CPB); c++) begin
      if (c > 1) @(negedge clock);
      if (c == drop_at) tx_enable = 1'b0;
      b = (c - 1) / CPB;
      if (tx !== exp_bits[b]) begin
        bad[b]      = 1;
        obs_bits[b] = tx;
      end
      if (frame_done !== 1'(c == int'(NB * CPB))) begin
        done_bad = 1;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== 1'b1) busy_bad = 1;
    end
    for (int i = 0; i < int'(NB); i++) begin
      n_cmp++;
      if (bad[i]) begin
        n_fail++;
        $display("FAIL frame_bit: data=%h bit %0d tx=%b, required %b", data, i, obs_bits[i],
                 exp_bits[i]);
      end
    end
    n_cmp++;
    if (done_bad) begin
      n_fail++;
      $display("FAIL frame_done: data=%h wrong at cycle %0d, required single pulse at %0d",
               data, done_cyc, NB * CPB);
    end
    n_cmp++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL busy_in_frame: data=%h busy dropped, required 1", data);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    tx_enable = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: %b required 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b required 0", busy); end
    n_cmp++;
    if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL rst_pop: %b required 0", fifo_pop); end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: %b required 0", frame_done);
    end
    reset = 1'b0;
    begin
      bit tx_bad, busy_bad, pop_bad;
      tx_bad = 0; busy_bad = 0; pop_bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        if (tx !== 1'b1) tx_bad = 1;
        if (busy !== 1'b0) busy_bad = 1;
        if (fifo_pop !== 1'b0) pop_bad = 1;
      end
      n_cmp++; if (tx_bad) begin n_fail++; $display("FAIL idle_tx: left 1, required 1"); end
      n_cmp++; if (busy_bad) begin n_fail++; $display("FAIL idle_busy: rose, required 0"); end
      n_cmp++; if (pop_bad) begin n_fail++; $display("FAIL idle_pop: rose, required 0"); end
    end
  endtask

  task automatic test_single(input logic [W-1:0] data);
    int p0, gap;
    p0 = pop_cnt;
    fq.push_back(data);
    capture_frame(data, -1, gap);
    repeat (5) @(negedge clock);
    n_cmp++;
    if (pop_cnt - p0 !== 1) begin
      n_fail++; $display("FAIL single_pops: data=%h %0d pops, required 1", data, pop_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0, gap;
    logic [W-1:0] words[3];
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) fq.push_back(words[i]);
    for (int i = 0; i < 3; i++) begin
      capture_frame(words[i], -1, gap);
      if (i > 0) begin
        n_cmp++;
        if (gap !== 2) begin
          n_fail++; $display("FAIL b2b_gap: frame %0d gap %0d, required 2", i, gap);
        end
      end
    end
    repeat (5) @(negedge clock);
    n_cmp++;
    if (pop_cnt - p0 !== 3) begin
      n_fail++; $display("FAIL b2b_pops: %0d pops, required 3", pop_cnt - p0);
    end
  endtask

  task automatic test_enable_drop();
    int p0, gap;
    p0 = pop_cnt;
    fq.push_back(8'h3C);
    fq.push_back(8'h55);
    capture_frame(8'h3C, 10, gap);
    repeat (60) @(negedge clock);
    n_cmp++;
    if (pop_cnt - p0 !== 1) begin
      n_fail++; $display("FAIL drop_pops: %0d pops while disabled, required 1", pop_cnt - p0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: %b required 0", busy); end
    tx_enable = 1'b1;
    capture_frame(8'h55, -1, gap);
    n_cmp++;
    if (pop_cnt - p0 !== 2) begin
      n_fail++; $display("FAIL drop_resume_pops: %0d pops, required 2", pop_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0, gap, waited;
    p0 = pop_cnt;
    fq.push_back(8'h96);
    fq.push_back(8'h5A);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (tx !== 1'b0 && waited < 300);
    n_cmp++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_start: tx=%b required 0", tx); end
    repeat (13) @(negedge clock);  // cycle 14: second cycle of data bit 2
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: %b required 1", tx); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: %b required 0", busy); end
    n_cmp++;
    if (fifo_pop !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_pop: %b required 0", fifo_pop);
    end
    reset = 1'b0;
    capture_frame(8'h5A, -1, gap);
    n_cmp++;
    if (pop_cnt - p0 !== 2) begin
      n_fail++; $display("FAIL mid_pops: %0d pops, required 2", pop_cnt - p0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    tx_enable = 1'b0;
    test_reset();
    test_single(8'hA5);
`ifdef UART_TX_PARITY_EN
    test_single(8'h07);
`endif
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    n_cmp++;
    if (double_pop !== 0) begin
      n_fail++; $display("FAIL pop_consecutive: %0d, required 0", double_pop);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the buffered UART byte queue and drives the TX line. It sits directly downstream of the buffering FIFO. When idle and the FIFO reports data, it requests one word, captures it one cycle later, and shifts it out as a standard asynchronous frame: start bit, LSB-first data bits, optional parity, then stop bit(s).

## Interface
- WIDTH, 8: data bits per frame; must equal the FIFO word width.
- CLOCKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_enable  input  1  permits starting new frames; a frame in progress always completes.
- fifo_empty  input  1  FIFO has no data.
- fifo_pop  output  1  one-cycle request for the FIFO to emit its head word.
- fifo_data  input  WIDTH  head word; valid exactly one cycle after fifo_pop.
- tx  output  1  serial line, idle high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Reset values: tx=1, busy=0, fifo_pop=0, frame_done=0, state IDLE, bit and baud counters 0.
- IDLE:
  - tx=1.
  - If tx_enable && !fifo_empty: assert fifo_pop for exactly one cycle and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: latch fifo_data into the shift register, clear the baud counter, go to START. fifo_pop=0.
- START: tx=0 for CLOCKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0]. At the end of each bit period, shift right and increment the bit counter. After WIDTH bits, go to PARITY if compiled in, else STOP.
- PARITY: tx = XOR of all WIDTH captured bits (even parity) for one bit period, then STOP.
- STOP: tx=1 for STOP_BITS×CLOCKS_PER_BIT cycles. frame_done pulses in the final cycle, then IDLE.
- Baud counter:
  - Width $clog2(CLOCKS_PER_BIT).
  - Counts 0..CLOCKS_PER_BIT-1; the bit-end tick is count==CLOCKS_PER_BIT-1.
  - Wraps to 0.
- Bit counter: width $clog2(WIDTH+1).
- fifo_empty and tx_enable are sampled only in IDLE. Changes during a frame have no effect.
- fifo_data is sampled only in FETCH. If fifo_data is 0 because the FIFO refused the pop, a 0 word is transmitted. The block relies on fifo_empty having been low when it popped.
- Reset mid-frame: the next cycle has tx=1 and state IDLE. The partial frame is abandoned and the popped word is lost. fifo_pop is never asserted in the reset cycle.

## Timing
- Pop issued in cycle N. Capture in N+1. tx falls in N+2.
- Frame length from tx fall to the end of stop: (1+WIDTH+P+STOP_BITS)×CLOCKS_PER_BIT cycles, with P=1 if parity is compiled in, else 0.
- Back-to-back frames: exactly 2 extra idle-high cycles (IDLE, FETCH) between the end of one stop bit and the next start bit.
- At most one fifo_pop per frame. fifo_pop is never high on two consecutive cycles.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and one even-parity bit follows the data bits.
- Undefined: no PARITY state; DATA goes directly to STOP; frame is start+data+stop only.

## Structure
- Shared package uart_pkg holds:
  - the state enum typedef uart_tx_state_t (IDLE, FETCH, START, DATA, PARITY, STOP);
  - the line-level constants UART_IDLE_LEVEL=1 and UART_START_LEVEL=0, for reuse by the receiver.
- Natural sub-module: uart_baud_gen, the baud counter.
  - Inputs: clock, reset, clear. Output: bit tick.
  - Parameterised by CLOCKS_PER_BIT; shared with the future receiver.

## Test plan
- Reset release with FIFO empty:
  - tx=1, busy=0, fifo_pop=0 held for 100 cycles.
- WIDTH=8, CLOCKS_PER_BIT=4, no parity, one word 0xA5:
  - fifo_pop pulses once.
  - tx then carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - frame_done pulses on the 40th cycle after tx falls.
- Same as above with UART_TX_PARITY_EN:
  - a parity bit 0 is inserted before stop; frame is 44 cycles.
  - Repeat with 0x07: parity bit 1.
- FIFO preloaded with 0x01, 0x80, 0xFF:
  - three frames in order.
  - exactly 2 idle-high cycles between each stop end and the next start.
  - exactly 3 fifo_pop pulses.
- tx_enable dropped during the data bits of 0x3C:
  - the frame completes intact.
  - no further pop until tx_enable returns, although the FIFO is non-empty.
- reset asserted in the 3rd data bit:
  - the next cycle has tx=1, busy=0.
  - after release, the next FIFO word transmits normally.
